// File: rtl/bus_sel_pkg.sv
// Shared definitions for the fd -> FIFO bus-select crossbar arbiter.
package bus_sel_pkg;

  localparam int unsigned DEF_PORT_NUM = 8;
  localparam int unsigned DEF_MAX_HOLD = 1024;
  localparam int unsigned DEF_HOLD_W   = 11;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } colState_e;

  // Bit position of "fd x requests / is granted fifo y" in the fd-side vectors.
  function automatic int unsigned fdBit(input int unsigned x, input int unsigned y,
                                        input int unsigned n);
    return x * n + y;
  endfunction

  // Bit position of "fifo y is connected to fd x" in the FIFO-side vector.
  function automatic int unsigned fifoBit(input int unsigned y, input int unsigned x,
                                          input int unsigned n);
    return y * n + x;
  endfunction

endpackage

// File: rtl/bus_sel_xbar_arbiter_if.sv
// Request/grant bundle between the frame decoders, the FIFOs and the arbiter.
interface bus_sel_xbar_arbiter_if
  import bus_sel_pkg::*;
#(
  parameter int unsigned PORT_NUM = DEF_PORT_NUM
);

  logic [PORT_NUM*PORT_NUM-1:0] fd_req;
  logic [PORT_NUM-1:0]          fd_last;
  logic [PORT_NUM-1:0]          fifo_ready;
  logic [PORT_NUM*PORT_NUM-1:0] fifo_bus_sel;
  logic [PORT_NUM*PORT_NUM-1:0] fd_grant;
  logic [PORT_NUM-1:0]          err_multi_req;
  logic [PORT_NUM-1:0]          timeout;

  modport master (
    output fd_req, fd_last, fifo_ready,
    input  fifo_bus_sel, fd_grant, err_multi_req, timeout
  );

  modport slave (
    input  fd_req, fd_last, fifo_ready,
    output fifo_bus_sel, fd_grant, err_multi_req, timeout
  );

endinterface

// File: rtl/bus_sel_rr_arb.sv
// One FIFO column: round-robin pick among qualified fds, then lock the grant
// until the owner finishes, aborts, or overstays MAX_HOLD cycles.
module bus_sel_rr_arb
  import bus_sel_pkg::*;
#(
  parameter int unsigned PORT_NUM = DEF_PORT_NUM,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
  parameter int unsigned HOLD_W   = DEF_HOLD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PORT_NUM-1:0] req_i,
  input  logic [PORT_NUM-1:0] rawReq_i,
  input  logic [PORT_NUM-1:0] last_i,
  input  logic                ready_i,
  output logic [PORT_NUM-1:0] grant_o,
  output logic                timeout_o
);

  localparam int unsigned PTR_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(PORT_NUM - 1);
  localparam logic [PTR_W:0]    PTR_WRAP   = (PTR_W+1)'(PORT_NUM);

  colState_e           state_q, state_d;
  logic [PORT_NUM-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   holdCnt_q, holdCnt_d;
  logic                timeout_q, timeout_d;

  logic [2*PORT_NUM-1:0] dblReq;
  logic [PORT_NUM-1:0]   rotReq;
  logic                  winFound;
  logic [PTR_W-1:0]      winIdx;
  logic [PTR_W:0]        winSum;
  logic                  ownerLast;
  logic                  ownerReq;

  assign dblReq    = {req_i, req_i} >> ptr_q;
  assign rotReq    = dblReq[PORT_NUM-1:0];
  assign ownerLast = |(grant_q & last_i);
  assign ownerReq  = |(grant_q & rawReq_i);

  // Find the first qualified requester at or after the pointer, wrapping.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    winSum   = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (!winFound && rotReq[i]) begin
        winFound = 1'b1;
        winSum   = {1'b0, ptr_q} + (PTR_W+1)'(i);
        if (winSum >= PTR_WRAP) begin
          winSum = winSum - PTR_WRAP;
        end
        winIdx = winSum[PTR_W-1:0];
      end
    end
  end

  // Column next-state: arbitrate in IDLE, hold and watch for release in LOCK.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    holdCnt_d = holdCnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (ready_i && winFound) begin
          grant_d   = PORT_NUM'(1) << winIdx;
          ptr_d     = (winIdx == PTR_LAST) ? '0 : winIdx + PTR_W'(1);
          holdCnt_d = '0;
          state_d   = LOCK;
        end
      end
      LOCK: begin
        if (ownerLast || !ownerReq) begin
          grant_d   = '0;
          holdCnt_d = '0;
          state_d   = IDLE;
        end else if (holdCnt_q == HOLD_LIMIT) begin
          grant_d   = '0;
          holdCnt_d = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (holdCnt_q != HOLD_SAT) begin
          holdCnt_d = holdCnt_q + HOLD_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Column state, grant, pointer and hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      holdCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      holdCnt_q <= holdCnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/bus_sel_xbar_arbiter.sv
// Square fd -> FIFO crossbar arbiter: qualifies fd requests, runs one
// round-robin column per FIFO and drives the grants both ways round.
module bus_sel_xbar_arbiter
  import bus_sel_pkg::*;
#(
  parameter int unsigned PORT_NUM = DEF_PORT_NUM,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
  parameter int unsigned HOLD_W   = DEF_HOLD_W
) (
  input logic                   clk,
  input logic                   rst_n,
  bus_sel_xbar_arbiter_if.slave bus
);

  logic [PORT_NUM-1:0] rowReq   [PORT_NUM];
  logic [PORT_NUM-1:0] colReq   [PORT_NUM];
  logic [PORT_NUM-1:0] colRaw   [PORT_NUM];
  logic [PORT_NUM-1:0] colGrant [PORT_NUM];
  logic [PORT_NUM-1:0] colTimeout;
  logic [PORT_NUM-1:0] multiHot;
  logic [PORT_NUM-1:0] busy;
  logic [PORT_NUM-1:0] errMulti_q, errMulti_d;

  for (genvar x = 0; x < PORT_NUM; x++) begin : g_row
    assign rowReq[x]   = bus.fd_req[fdBit(x, 0, PORT_NUM) +: PORT_NUM];
    assign multiHot[x] = |(rowReq[x] & (rowReq[x] - PORT_NUM'(1)));
  end

  // An fd already owning any column is kept out of every other column.
  always_comb begin
    busy = '0;
    for (int y = 0; y < PORT_NUM; y++) begin
      busy = busy | colGrant[y];
    end
  end

  // Transpose rows into per-column request vectors, dropping multi-hot and busy fds.
  always_comb begin
    colReq = '{default: '0};
    colRaw = '{default: '0};
    for (int y = 0; y < PORT_NUM; y++) begin
      for (int x = 0; x < PORT_NUM; x++) begin
        colRaw[y][x] = rowReq[x][y];
        colReq[y][x] = rowReq[x][y] & ~multiHot[x] & ~busy[x];
      end
    end
  end

  for (genvar y = 0; y < PORT_NUM; y++) begin : g_col
    bus_sel_rr_arb #(
      .PORT_NUM (PORT_NUM),
      .MAX_HOLD (MAX_HOLD),
      .HOLD_W   (HOLD_W)
    ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (colReq[y]),
      .rawReq_i  (colRaw[y]),
      .last_i    (bus.fd_last),
      .ready_i   (bus.fifo_ready[y]),
      .grant_o   (colGrant[y]),
      .timeout_o (colTimeout[y])
    );

    for (genvar x = 0; x < PORT_NUM; x++) begin : g_map
      assign bus.fifo_bus_sel[fifoBit(y, x, PORT_NUM)] = colGrant[y][x];
      assign bus.fd_grant[fdBit(x, y, PORT_NUM)]       = colGrant[y][x];
    end
  end

  assign errMulti_d = multiHot;

  // Flag a malformed multi-hot request one cycle after it is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errMulti_q <= '0;
    end else begin
      errMulti_q <= errMulti_d;
    end
  end

  assign bus.err_multi_req = errMulti_q;
  assign bus.timeout       = colTimeout;

endmodule

// File: tb/tb_bus_sel_xbar_arbiter.sv
// Directed bench for the bus-select crossbar arbiter (8x8, MAX_HOLD=4).
module tb_bus_sel_xbar_arbiter;

  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nChecks = 0;
  int   nFail = 0;
  int   rrOrder [4] = '{1, 2, 5, 1};

  bus_sel_xbar_arbiter_if #(.PORT_NUM(N)) bus ();

  bus_sel_xbar_arbiter #(
    .PORT_NUM (N),
    .MAX_HOLD (4),
    .HOLD_W   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] bit64(input int idx);
    logic [63:0] one;
    one = 64'd1;
    return one << idx;
  endfunction

  task automatic applyStimulus(input logic [63:0] req, input logic [7:0] last,
                               input logic [7:0] ready);
    bus.fd_req     = req;
    bus.fd_last    = last;
    bus.fifo_ready = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus({$urandom, $urandom}, 8'h00, 8'hFF);
    stepCycle();
    stepCycle();
    checkOutput("rst_sel", bus.fifo_bus_sel, 64'd0);
    checkOutput("rst_gnt", bus.fd_grant, 64'd0);
    checkOutput("rst_err", 64'(bus.err_multi_req), 64'd0);
    checkOutput("rst_to", 64'(bus.timeout), 64'd0);

    // First grant latency: fd 0 -> fifo 3
    applyStimulus(64'd0, 8'h00, 8'hFF);
    rst_n = 1'b1;
    stepCycle();
    applyStimulus(bit64(0*8+3), 8'h00, 8'hFF);
    checkOutput("lat_pre", bus.fifo_bus_sel, 64'd0);
    stepCycle();
    checkOutput("lat_sel", bus.fifo_bus_sel, bit64(3*8+0));
    checkOutput("lat_gnt", bus.fd_grant, bit64(0*8+3));
    applyStimulus(64'd0, 8'h00, 8'hFF);
    stepCycle();
    checkOutput("abort_sel", bus.fifo_bus_sel, 64'd0);

    // Round robin on fifo 4 among fds 1, 2, 5
    applyStimulus(bit64(1*8+4) | bit64(2*8+4) | bit64(5*8+4), 8'h00, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      stepCycle();
      checkOutput($sformatf("rr%0d_gnt", k), bus.fifo_bus_sel, bit64(4*8+rrOrder[k]));
      stepCycle();
      stepCycle();
      checkOutput($sformatf("rr%0d_hold", k), bus.fd_grant, bit64(rrOrder[k]*8+4));
      bus.fd_last = 8'(bit64(rrOrder[k]));
      stepCycle();
      checkOutput($sformatf("rr%0d_bubble", k), bus.fifo_bus_sel, 64'd0);
      bus.fd_last = 8'h00;
      if (k == 3) bus.fd_req = 64'd0;
    end

    // Lock under backpressure on fifo 2
    applyStimulus(bit64(0*8+2), 8'h00, 8'hFF);
    stepCycle();
    checkOutput("bp_gnt", bus.fifo_bus_sel, bit64(2*8+0));
    applyStimulus(bit64(0*8+2) | bit64(4*8+2), 8'h00, 8'hFB);
    stepCycle();
    checkOutput("bp_hold1", bus.fifo_bus_sel, bit64(2*8+0));
    stepCycle();
    checkOutput("bp_hold2", bus.fifo_bus_sel, bit64(2*8+0));
    bus.fd_last = 8'h01;
    stepCycle();
    checkOutput("bp_rel", bus.fifo_bus_sel, 64'd0);
    applyStimulus(bit64(4*8+2), 8'h00, 8'hFB);
    stepCycle();
    checkOutput("bp_wait1", bus.fifo_bus_sel, 64'd0);
    stepCycle();
    checkOutput("bp_wait2", bus.fifo_bus_sel, 64'd0);
    bus.fifo_ready = 8'hFF;
    stepCycle();
    checkOutput("bp_new_sel", bus.fifo_bus_sel, bit64(2*8+4));
    checkOutput("bp_new_gnt", bus.fd_grant, bit64(4*8+2));
    applyStimulus(64'd0, 8'h00, 8'hFF);
    stepCycle();

    // Multi-hot row from fd 6
    applyStimulus(bit64(6*8+1) | bit64(6*8+7), 8'h00, 8'hFF);
    checkOutput("mh_err_pre", 64'(bus.err_multi_req), 64'd0);
    stepCycle();
    checkOutput("mh_err", 64'(bus.err_multi_req), 64'h40);
    checkOutput("mh_sel", bus.fifo_bus_sel, 64'd0);
    applyStimulus(64'd0, 8'h00, 8'hFF);
    stepCycle();
    checkOutput("mh_err_end", 64'(bus.err_multi_req), 64'd0);
    checkOutput("mh_sel_end", bus.fifo_bus_sel, 64'd0);

    // Hold timeout: fd 3 on fifo 0, no fd_last
    applyStimulus(bit64(3*8+0), 8'h00, 8'hFF);
    for (int c = 0; c < 4; c++) begin
      stepCycle();
      checkOutput($sformatf("to_hold%0d", c), bus.fifo_bus_sel, bit64(0*8+3));
      checkOutput($sformatf("to_pulse%0d", c), 64'(bus.timeout), 64'd0);
    end
    stepCycle();
    checkOutput("to_drop_sel", bus.fifo_bus_sel, 64'd0);
    checkOutput("to_drop_pulse", 64'(bus.timeout), 64'd1);
    stepCycle();
    checkOutput("to_regrant", bus.fifo_bus_sel, bit64(0*8+3));
    checkOutput("to_pulse_end", 64'(bus.timeout), 64'd0);

    // Async reset while fd 3 holds fifo 0
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_sel", bus.fifo_bus_sel, 64'd0);
    checkOutput("arst_gnt", bus.fd_grant, 64'd0);
    applyStimulus(bit64(0*8+0) | bit64(3*8+0) | bit64(5*8+0), 8'h00, 8'hFF);
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
    checkOutput("arst_ptr_sel", bus.fifo_bus_sel, bit64(0*8+0));
    checkOutput("arst_ptr_gnt", bus.fd_grant, bit64(0*8+0));
    applyStimulus(64'd0, 8'h00, 8'hFF);
    stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/bus_sel_xbar_arbiter.md
Name: bus_sel_xbar_arbiter

Overview:
Parametrised successor to the fixed 8x8 bus-select transpose between frame decoders (fd) and output FIFOs. Each fd raises a one-hot request for a destination FIFO. Each FIFO column runs an independent round-robin arbiter with packet locking and a hold timeout. Grants are registered and driven both FIFO-side (fifo y, bit x) and fd-side (fd x, bit y), preserving the fd_x[y] <-> fifo_y[x] mapping.

Parameters:
PORT_NUM, 8, number of fd sources and of FIFO destinations (square crossbar, >=2)
MAX_HOLD, 1024, max cycles a grant may be held without fd_last before forced release (>=2)
HOLD_W, 11, counter width, >= clog2(MAX_HOLD+1)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
fd_req  input  PORT_NUM*PORT_NUM  bit x*PORT_NUM+y: fd x requests fifo y; must be one-hot or zero per fd
fd_last  input  PORT_NUM  fd x is on the final beat of its packet this cycle
fifo_ready  input  PORT_NUM  fifo y can accept a new packet (sampled only when arbitrating)
fifo_bus_sel  output  PORT_NUM*PORT_NUM  bit y*PORT_NUM+x: fifo y is connected to fd x (one-hot or zero per fifo)
fd_grant  output  PORT_NUM*PORT_NUM  bit x*PORT_NUM+y: transposed copy of fifo_bus_sel
err_multi_req  output  PORT_NUM  1-cycle pulse: fd x presented a multi-hot request
timeout  output  PORT_NUM  1-cycle pulse: fifo y grant force-released by MAX_HOLD

Behaviour:
- Reset (async, rst_n=0): all grants 0, all columns IDLE, RR pointers 0, hold counters 0, err_multi_req 0, timeout 0. Reset mid-packet drops grants immediately; no completion owed.
- Request qualification: a row with >1 bit set is ignored for all columns that cycle; err_multi_req[x] pulses the next cycle. A row is also masked from arbitration while fd x holds a grant in any column.
- Per-column FSM (fifo y), states IDLE, LOCK:
  - IDLE: if fifo_ready[y]=1 and any qualified request in column y, pick the first requester at or after ptr[y], scanning upward with wrap. Register the one-hot grant; enter LOCK; ptr[y] <= winner+1 mod PORT_NUM; counter <= 0. Latency: request at cycle N -> grant visible at N+1.
  - LOCK: grant held irrespective of fifo_ready. Counter increments per cycle, saturating.
  - Release (to IDLE, grant 0 next cycle) on: fd_last[owner]=1; or owner's request bit for y deasserted (abort); or counter reaches MAX_HOLD-1 (timeout[y] pulses the same edge).
  - Simultaneous fd_last and timeout: normal release; timeout is not pulsed.
  - One bubble cycle after release: re-arbitration occurs in the first IDLE cycle. No same-cycle hand-over.
- Two columns may arbitrate the same fd in the same cycle only if the row is multi-hot, which the qualification step already blocks. An fd never holds more than one grant.
- fd_grant equals the exact transpose of fifo_bus_sel at all times. Both come from the same flops; no added latency.
- All outputs are registered; no combinational input-to-output path.

Decomposition:
- Package bus_sel_pkg: PORT_NUM default, index helpers for bit x*PORT_NUM+y, and column state encoding (IDLE=0, LOCK=1).
- Sub-module bus_sel_rr_arb: one column FSM containing the RR pointer, hold counter and grant register. Instantiated PORT_NUM times by generate. The top level holds request qualification (multi-hot detect, busy mask) and the transpose wiring.

Test Plan:
- Reset: hold rst_n=0, drive random fd_req -> all outputs 0. Release, set fd_req[0*8+3]=1, fifo_ready=all 1 -> fifo_bus_sel bit 3*8+0 and fd_grant bit 0*8+3 both rise exactly 1 cycle later.
- Round robin: fds 1, 2 and 5 all request fifo 4 continuously, each pulsing fd_last 3 cycles into its grant -> grant order 1, 2, 5, 1, with one idle cycle between grants.
- Lock/backpressure: fd 0 granted fifo 2, then fifo_ready[2]=0 -> grant held. fd_last[0] -> released next cycle. New requester is not granted until fifo_ready[2]=1.
- Multi-hot: fd 6 drives fd_req bits for fifos 1 and 7 -> no grant in either column; err_multi_req[6] pulses 1 cycle later.
- Timeout: MAX_HOLD=4, fd 3 holds a request to fifo 0 with no fd_last -> grant held 4 cycles, then drops with timeout[0] pulsing; re-grant only after the bubble cycle.
- Async reset mid-LOCK: assert rst_n between clock edges -> grants clear without waiting for a clock edge; ptr returns to 0, so fd 0 wins first after release.
